// File: rtl/dram_cache_pkg.sv
// Shared widths, request field positions and result classes
// for the DRAM-cache tag lookup scheduler.
package dram_cache_pkg;

  localparam int REQ_W  = 81;
  localparam int TAG_W  = 8;
  localparam int IDX_W  = 8;
  localparam int DATA_W = 64;

  localparam int WR_BIT = 80;
  localparam int WD_HI  = 79;
  localparam int WD_LO  = 16;
  localparam int TAG_HI = 15;
  localparam int TAG_LO = 8;
  localparam int IDX_HI = 7;
  localparam int IDX_LO = 0;

  localparam int MAX_OUT_DEF = 4;

  typedef enum logic [1:0] {
    CLS_RD_HIT  = 2'b00,
    CLS_RD_MISS = 2'b01,
    CLS_WR_HIT  = 2'b10,
    CLS_WR_MISS = 2'b11
  } cls_e;

  function automatic cls_e classify(
    input logic wr,
    input logic hit
  );
    return cls_e'({wr, ~hit});
  endfunction

endpackage

// File: rtl/inflight_fifo.sv
// Synchronous FIFO holding requests whose tag read is outstanding.
// Push on full and pop on empty are ignored.
module inflight_fifo #(
  parameter int WIDTH = 81,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; contents are only visible through valid pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tag_lookup_sched.sv
// Issues tag-array reads for host requests, matches in-order
// responses against the request tag and emits a hit/miss class.
module tag_lookup_sched
  import dram_cache_pkg::*;
#(
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [REQ_W-1:0]  req_data_i,
  output logic              ar_valid_o,
  input  logic              ar_ready_i,
  output logic [IDX_W-1:0]  ar_idx_o,
  input  logic              rvalid_i,
  output logic              rready_o,
  input  logic [TAG_W-1:0]  rtag_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [1:0]        out_class_o,
  output logic [REQ_W-1:0]  out_req_o,
  output logic [DATA_W-1:0] out_rdata_o,
  output logic [3:0]        inflight_o,
  output logic [15:0]       hit_cnt_o,
  output logic [15:0]       miss_cnt_o,
  output logic              err_o
);

  localparam int CW = $clog2(MAX_OUT) + 1;

  logic              ar_v;
  logic [REQ_W-1:0]  ar_req;
  logic              out_v;
  cls_e              out_cls;
  logic [REQ_W-1:0]  out_req;
  logic [DATA_W-1:0] out_rdata;
  logic [CW-1:0]     cnt;
  logic              f_full;
  logic              f_empty;
  logic [REQ_W-1:0]  head;
  logic              room;
  logic              req_hs;
  logic              ar_hs;
  logic              r_hs;
  logic              pop;
  logic              out_hs;
  logic              hit;
  logic              err;
  logic [15:0]       hit_cnt;
  logic [15:0]       miss_cnt;

  assign room        = (int'(cnt) + int'(ar_v)) < MAX_OUT;
  assign req_ready_o = !rst && (!ar_v || ar_ready_i) && room;
  assign ar_valid_o  = !rst && ar_v;
  assign rready_o    = !rst && (!out_v || out_ready_i);
  assign out_valid_o = !rst && out_v;

  assign req_hs = req_valid_i && req_ready_o;
  assign ar_hs  = ar_valid_o && ar_ready_i;
  assign r_hs   = rvalid_i && rready_o;
  assign pop    = r_hs && !f_empty;
  assign out_hs = out_valid_o && out_ready_i;
  assign hit    = (rtag_i == head[TAG_HI:TAG_LO]);

  assign ar_idx_o    = ar_req[IDX_HI:IDX_LO];
  assign out_class_o = out_cls;
  assign out_req_o   = out_req;
  assign out_rdata_o = out_rdata;
  assign inflight_o  = 4'(cnt);
  assign hit_cnt_o   = hit_cnt;
  assign miss_cnt_o  = miss_cnt;
  assign err_o       = err;

  inflight_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (MAX_OUT)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ar_hs),
    .push_data (ar_req),
    .pop       (pop),
    .pop_data  (head),
    .full      (f_full),
    .empty     (f_empty),
    .count     (cnt)
  );

  // AR stage: refill in the same cycle it drains
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_v   <= 1'b0;
      ar_req <= '0;
    end else if (req_hs) begin
      ar_v   <= 1'b1;
      ar_req <= req_data_i;
    end else if (ar_hs) begin
      ar_v   <= 1'b0;
    end
  end

  // Output stage: capture the classified response
  always_ff @(posedge clk) begin
    if (rst) begin
      out_v     <= 1'b0;
      out_cls   <= CLS_RD_HIT;
      out_req   <= '0;
      out_rdata <= '0;
    end else if (pop) begin
      out_v     <= 1'b1;
      out_cls   <= classify(head[WR_BIT], hit);
      out_req   <= head;
      out_rdata <= rdata_i;
    end else if (out_hs) begin
      out_v     <= 1'b0;
    end
  end

  // Sticky error for responses with nothing outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (r_hs && f_empty) begin
      err <= 1'b1;
    end
  end

  // Hit/miss statistics counted at output handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (out_hs) begin
      if (out_cls[0]) miss_cnt <= miss_cnt + 16'd1;
      else            hit_cnt  <= hit_cnt + 16'd1;
    end
  end

  logic unused;
  assign unused = f_full;

endmodule

// File: tb/tb_tag_lookup_sched.sv
// Directed self-checking bench for tag_lookup_sched.
// Inputs change 1ns after posedge; checks happen at negedge.
module tb_tag_lookup_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [80:0] req_data;
  logic        ar_valid;
  logic        ar_ready;
  logic [7:0]  ar_idx;
  logic        rvalid;
  logic        rready;
  logic [7:0]  rtag;
  logic [63:0] rdata;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_class;
  logic [80:0] out_req;
  logic [63:0] out_rdata;
  logic [3:0]  inflight;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic        err;

  int vecs = 0;
  int errs = 0;
  int ar_hs_cnt = 0;

  logic [1:0]  q_cls[$];
  logic [80:0] q_req[$];
  logic [63:0] q_rd[$];

  tag_lookup_sched #(.MAX_OUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .ar_valid_o  (ar_valid),
    .ar_ready_i  (ar_ready),
    .ar_idx_o    (ar_idx),
    .rvalid_i    (rvalid),
    .rready_o    (rready),
    .rtag_i      (rtag),
    .rdata_i     (rdata),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_class_o (out_class),
    .out_req_o   (out_req),
    .out_rdata_o (out_rdata),
    .inflight_o  (inflight),
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ar_valid && ar_ready) ar_hs_cnt++;
    if (out_valid && out_ready) begin
      q_cls.push_back(out_class);
      q_req.push_back(out_req);
      q_rd.push_back(out_rdata);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [80:0] d);
    bit ok = 0;
    req_valid = 1'b1;
    req_data  = d;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL send_req idx=%h: not accepted, required accept", d[7:0]);
    end
  endtask

  task automatic respond(input logic [7:0] t, input logic [63:0] d);
    bit ok = 0;
    rvalid = 1'b1;
    rtag   = t;
    rdata  = d;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (rready) ok = 1;
      @(posedge clk);
      #1;
    end
    rvalid = 1'b0;
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL respond tag=%h: rready never high, required high", t);
    end
  endtask

  task automatic wait_inflight(input int n);
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (inflight == 4'(n)) ok = 1;
      @(posedge clk);
      #1;
    end
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL wait_inflight: got %0d, required %0d", inflight, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 0; req_data = '0;
    ar_ready = 0; rvalid = 0; rtag = '0; rdata = '0;
    out_ready = 0;
    @(negedge clk);
    vecs++;
    if ({req_ready, ar_valid, rready, out_valid} !== 4'b0) begin
      errs++;
      $display("FAIL reset_handshake: got %b, required 0000",
               {req_ready, ar_valid, rready, out_valid});
    end
    @(posedge clk); #1;
    @(negedge clk);
    vecs++;
    if (inflight !== 4'd0 || hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || err !== 1'b0) begin
      errs++;
      $display("FAIL reset_status: inflight=%0d hit=%0d miss=%0d err=%b, required 0",
               inflight, hit_cnt, miss_cnt, err);
    end
    vecs++;
    if (out_req !== 81'd0 || out_rdata !== 64'd0 || out_class !== 2'd0 || ar_idx !== 8'd0) begin
      errs++;
      $display("FAIL reset_payload: req=%h rdata=%h cls=%b idx=%h, required 0",
               out_req, out_rdata, out_class, ar_idx);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ar_ready = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_read_hit();
    logic [80:0] r;
    r = {1'b0, 64'd0, 8'h00, 8'h0A};
    send_req(r);
    vecs++;
    if (ar_valid !== 1'b1 || ar_idx !== 8'h0A) begin
      errs++;
      $display("FAIL ar_issue: valid=%b idx=%h, required 1 0a", ar_valid, ar_idx);
    end
    wait_inflight(1);
    respond(8'h00, 64'd100);
    idle(2);
    vecs++;
    if (q_cls.size() == 0) begin
      errs++;
      $display("FAIL read_hit_out: no output, required one");
    end else begin
      if (q_cls.pop_front() !== 2'b00 || q_req.pop_front() !== r || q_rd.pop_front() !== 64'd100) begin
        errs++;
        $display("FAIL read_hit_out: class/req/rdata wrong, required 00 %h 100", r);
      end
    end
    vecs++;
    if (hit_cnt !== 16'd1 || miss_cnt !== 16'd0) begin
      errs++;
      $display("FAIL read_hit_cnt: hit=%0d miss=%0d, required 1 0", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_classes();
    logic [80:0] r [3];
    logic [1:0]  c [3];
    logic [1:0]  gc;
    logic [80:0] gr;
    logic [63:0] gd;
    r[0] = {1'b0, 64'd0, 8'h0B, 8'h0A}; c[0] = 2'b01;
    r[1] = {1'b1, 64'd5, 8'h0A, 8'h0A}; c[1] = 2'b10;
    r[2] = {1'b1, 64'd5, 8'h0C, 8'h0A}; c[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      send_req(r[i]);
      wait_inflight(1);
      respond(8'h0A, 64'(200 + i));
      idle(2);
      vecs++;
      if (q_cls.size() == 0) begin
        errs++;
        $display("FAIL class_%0d: no output, required one", i);
      end else begin
        gc = q_cls.pop_front();
        gr = q_req.pop_front();
        gd = q_rd.pop_front();
        if (gc !== c[i] || gr !== r[i] || gd !== 64'(200 + i)) begin
          errs++;
          $display("FAIL class_%0d: got %b %h %0d, required %b %h %0d",
                   i, gc, gr, gd, c[i], r[i], 200 + i);
        end
      end
    end
    vecs++;
    if (hit_cnt !== 16'd2 || miss_cnt !== 16'd2) begin
      errs++;
      $display("FAIL class_cnt: hit=%0d miss=%0d, required 2 2", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_max_out();
    int acc = 0;
    int base;
    logic [7:0] gi;
    base = ar_hs_cnt;
    req_valid = 1'b1;
    req_data = {1'b0, 64'd0, 8'h00, 8'h20};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_valid && req_ready) acc++;
      @(posedge clk); #1;
      req_data = {1'b0, 64'd0, 8'h00, 8'(8'h20 + acc)};
      if (acc == 6) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if (acc != 4 || ar_hs_cnt - base != 4) begin
      errs++;
      $display("FAIL max_out_accept: acc=%0d ar=%0d, required 4 4", acc, ar_hs_cnt - base);
    end
    vecs++;
    if (req_ready !== 1'b0 || inflight !== 4'd4) begin
      errs++;
      $display("FAIL max_out_full: ready=%b inflight=%0d, required 0 4", req_ready, inflight);
    end
    @(posedge clk); #1;
    respond(8'h00, 64'h20);
    @(negedge clk);
    vecs++;
    if (inflight !== 4'd3 || req_ready !== 1'b1) begin
      errs++;
      $display("FAIL max_out_release: inflight=%0d ready=%b, required 3 1", inflight, req_ready);
    end
    @(posedge clk); #1;
    send_req({1'b0, 64'd0, 8'h00, 8'h24});
    for (int i = 1; i < 5; i++) respond(8'h00, 64'(8'h20 + i));
    idle(3);
    vecs++;
    if (q_cls.size() != 5) begin
      errs++;
      $display("FAIL max_out_count: got %0d outputs, required 5", q_cls.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        gi = q_req[i][7:0];
        vecs++;
        if (gi !== 8'(8'h20 + i) || q_cls[i] !== 2'b00 || q_rd[i] !== 64'(8'h20 + i)) begin
          errs++;
          $display("FAIL max_out_order_%0d: idx=%h cls=%b, required %h 00", i, gi, q_cls[i], 8'h20 + i);
        end
      end
    end
    q_cls.delete(); q_req.delete(); q_rd.delete();
    vecs++;
    if (hit_cnt !== 16'd7) begin
      errs++;
      $display("FAIL max_out_hits: got %0d, required 7", hit_cnt);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_req({1'b0, 64'd0, 8'h01, 8'h30});
    send_req({1'b0, 64'd0, 8'h01, 8'h31});
    wait_inflight(2);
    respond(8'h01, 64'h30);
    rvalid = 1'b1; rtag = 8'h01; rdata = 64'h31;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++;
      if (out_valid !== 1'b1 || out_req[7:0] !== 8'h30 || out_rdata !== 64'h30 ||
          rready !== 1'b0 || inflight !== 4'd1) begin
        errs++;
        $display("FAIL stall_%0d: v=%b idx=%h rd=%h rready=%b infl=%0d, required 1 30 30 0 1",
                 i, out_valid, out_req[7:0], out_rdata, rready, inflight);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    respond(8'h01, 64'h31);
    idle(3);
    vecs++;
    if (q_req.size() != 2) begin
      errs++;
      $display("FAIL drain_count: got %0d, required 2", q_req.size());
    end else if (q_req[0][7:0] !== 8'h30 || q_req[1][7:0] !== 8'h31 ||
                 q_rd[0] !== 64'h30 || q_rd[1] !== 64'h31) begin
      errs++;
      $display("FAIL drain_order: got %h %h, required 30 31", q_req[0][7:0], q_req[1][7:0]);
    end
    q_cls.delete(); q_req.delete(); q_rd.delete();
  endtask

  task automatic test_err();
    vecs++;
    if (inflight !== 4'd0 || err !== 1'b0) begin
      errs++;
      $display("FAIL err_pre: inflight=%0d err=%b, required 0 0", inflight, err);
    end
    respond(8'h00, 64'hDEAD);
    idle(3);
    vecs++;
    if (err !== 1'b1 || q_cls.size() != 0) begin
      errs++;
      $display("FAIL err_set: err=%b outs=%0d, required 1 0", err, q_cls.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [80:0] r;
    for (int i = 0; i < 3; i++) send_req({1'b0, 64'd0, 8'h00, 8'(8'h40 + i)});
    idle(2);
    vecs++;
    if (inflight !== 4'd3) begin
      errs++;
      $display("FAIL mid_pre: inflight=%0d, required 3", inflight);
    end
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if ({req_ready, ar_valid, rready, out_valid} !== 4'b0) begin
      errs++;
      $display("FAIL mid_rst_hs: got %b, required 0000", {req_ready, ar_valid, rready, out_valid});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if (inflight !== 4'd0 || err !== 1'b0 || hit_cnt !== 16'd0 ||
        miss_cnt !== 16'd0 || out_valid !== 1'b0 || req_ready !== 1'b1) begin
      errs++;
      $display("FAIL mid_post: infl=%0d err=%b hit=%0d miss=%0d ov=%b rr=%b, required 0 0 0 0 0 1",
               inflight, err, hit_cnt, miss_cnt, out_valid, req_ready);
    end
    @(posedge clk); #1;
    idle(4);
    vecs++;
    if (q_cls.size() != 0 || ar_hs_cnt < 0) begin
      errs++;
      $display("FAIL mid_stale: got %0d outputs, required 0", q_cls.size());
    end
    r = {1'b0, 64'd0, 8'h05, 8'h50};
    send_req(r);
    wait_inflight(1);
    respond(8'h05, 64'd77);
    idle(2);
    vecs++;
    if (q_req.size() != 1 || q_req[0] !== r || q_rd[0] !== 64'd77 || hit_cnt !== 16'd1) begin
      errs++;
      $display("FAIL mid_resume: outs=%0d hit=%0d, required 1 1", q_req.size(), hit_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_hit();
    test_classes();
    test_max_out();
    test_backpressure();
    test_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
